// File: rtl/nunchuck_i2c_target_pkg.sv
// ============================================================================
// nunchuck_pkg : shared nunchuck types, protocol constants and report packing
// Rev 1.0
// ============================================================================
`default_nettype none

package nunchuck_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_REG       = 4'd3,
    ST_REG_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RD_MACK   = 4'd8,
    ST_WAIT_STOP = 4'd9
  } state_e;

  localparam logic [6:0] NUNCHUCK_ADDR = 7'h52;
  localparam logic [7:0] INIT_REG1     = 8'hF0;
  localparam logic [7:0] INIT_VAL1     = 8'h55;
  localparam logic [7:0] INIT_REG2     = 8'hFB;
  localparam logic [7:0] INIT_VAL2     = 8'h00;
  localparam int         REPORT_BYTES  = 6;

  // Byte n of the report sits at bits [8n+7:8n]; buttons are active-low on the wire.
  function automatic logic [8*REPORT_BYTES-1:0] pack_report(
    input logic [7:0] sx,
    input logic [7:0] sy,
    input logic [9:0] ax,
    input logic [9:0] ay,
    input logic [9:0] az,
    input logic       z,
    input logic       c
  );
    pack_report = {{az[1:0], ay[1:0], ax[1:0], ~c, ~z},
                   az[9:2], ay[9:2], ax[9:2], sy, sx};
  endfunction

endpackage

`default_nettype wire

// File: rtl/nunchuck_i2c_target_if.sv
// ============================================================================
// nunchuck_i2c_target_if : I2C bus lines seen by the nunchuck target
// Rev 1.0
// ============================================================================
`default_nettype none

interface nunchuck_i2c_target_if;
  logic scl_in;
  logic sda_in;
  logic sda_oe;

  modport master (output scl_in, output sda_in, input sda_oe);
  modport slave  (input scl_in, input sda_in, output sda_oe);
endinterface

`default_nettype wire

// File: rtl/nunchuck_i2c_target_bus_sync.sv
// ============================================================================
// i2c_bus_sync : SCL/SDA synchronizer with edge and START/STOP detection
// Rev 1.0
// ============================================================================
`default_nettype none

module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  wire logic clock,
  input  wire logic rst,
  input  wire logic scl_in,
  input  wire logic sda_in,
  output logic      sda_lvl,
  output logic      scl_rise,
  output logic      scl_fall,
  output logic      start_det,
  output logic      stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_hist_q, scl_hist_d;
  logic                   sda_hist_q, sda_hist_d;
  logic                   scl_s;
  logic                   sda_s;

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  always_comb begin
    scl_sync_d[0] = scl_in;
    sda_sync_d[0] = sda_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      scl_sync_d[i] = scl_sync_q[i-1];
      sda_sync_d[i] = sda_sync_q[i-1];
    end
    scl_hist_d = scl_s;
    sda_hist_d = sda_s;
  end

  // Idle bus is high on both lines, so reset to 1 to avoid a phantom edge.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_hist_q <= scl_hist_d;
      sda_hist_q <= sda_hist_d;
    end
  end

  assign sda_lvl   = sda_s;
  assign scl_rise  = scl_s & ~scl_hist_q;
  assign scl_fall  = ~scl_s & scl_hist_q;
  assign start_det = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
  assign stop_det  = scl_s & scl_hist_q & ~sda_hist_q & sda_s;

endmodule

`default_nettype wire

// File: rtl/nunchuck_i2c_target.sv
// ============================================================================
// nunchuck_i2c_target : I2C target emulating a Wii nunchuck (unencrypted report)
// Rev 1.0
// ============================================================================
`default_nettype none

module nunchuck_i2c_target
  import nunchuck_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = NUNCHUCK_ADDR,
  parameter int         MAX_BYTES   = REPORT_BYTES,
  parameter int         SYNC_STAGES = 2
) (
  input  wire logic       clock,
  input  wire logic       rst,
  nunchuck_i2c_target_if.slave bus,
  input  wire logic [7:0] stick_x,
  input  wire logic [7:0] stick_y,
  input  wire logic [9:0] accel_x,
  input  wire logic [9:0] accel_y,
  input  wire logic [9:0] accel_z,
  input  wire logic       z,
  input  wire logic       c,
  output logic            handshake_done,
  output logic            busy
);

  localparam int SNAP_N = (MAX_BYTES < REPORT_BYTES) ? MAX_BYTES : REPORT_BYTES;

  logic sda_lvl, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clock     (clock),
    .rst       (rst),
    .scl_in    (bus.scl_in),
    .sda_in    (bus.sda_in),
    .sda_lvl   (sda_lvl),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  state_e      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  tx_q, tx_d;
  logic [7:0]  reg_ptr_q, reg_ptr_d;
  logic        oe_q, oe_d;
  logic        busy_q, busy_d;
  logic        init1_q, init1_d;
  logic        hs_q, hs_d;
  logic        snap_pend_q, snap_pend_d;
  logic [7:0]  snap_q [MAX_BYTES];
  logic [7:0]  snap_d [MAX_BYTES];

  logic [8*REPORT_BYTES-1:0] report;
  logic [7:0]  ptr_inc;
  logic [7:0]  rd_byte, nxt_byte;
  logic        last_bit, addr_match;

  assign report     = pack_report(stick_x, stick_y, accel_x, accel_y, accel_z, z, c);
  assign ptr_inc    = reg_ptr_q + 8'd1;
  assign last_bit   = (bit_cnt_q == 4'd8);
  assign addr_match = (shift_q[7:1] == DEV_ADDR);

  // Bytes served for the current and the following pointer; 0xFF until the handshake is done.
  always_comb begin
    rd_byte  = 8'hFF;
    nxt_byte = 8'hFF;
    if (hs_q) begin
      for (int i = 0; i < MAX_BYTES; i++) begin
        if (reg_ptr_q == 8'(i)) rd_byte  = snap_q[i];
        if (ptr_inc   == 8'(i)) nxt_byte = snap_q[i];
      end
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 8'd0;
      tx_q        <= 8'hFF;
      reg_ptr_q   <= 8'd0;
      oe_q        <= 1'b0;
      busy_q      <= 1'b0;
      init1_q     <= 1'b0;
      hs_q        <= 1'b0;
      snap_pend_q <= 1'b0;
      for (int i = 0; i < MAX_BYTES; i++) snap_q[i] <= 8'hFF;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      reg_ptr_q   <= reg_ptr_d;
      oe_q        <= oe_d;
      busy_q      <= busy_d;
      init1_q     <= init1_d;
      hs_q        <= hs_d;
      snap_pend_q <= snap_pend_d;
      for (int i = 0; i < MAX_BYTES; i++) snap_q[i] <= snap_d[i];
    end
  end

  always_comb begin
    state_d = state_q;
    if (stop_det) begin
      state_d = ST_IDLE;
    end else if (start_det) begin
      state_d = ST_ADDR;
    end else if (scl_fall) begin
      case (state_q)
        ST_ADDR:      if (last_bit) state_d = addr_match ? ST_ADDR_ACK : ST_WAIT_STOP;
        ST_ADDR_ACK:  state_d = shift_q[0] ? ST_RDATA : ST_REG;
        ST_REG:       if (last_bit) state_d = ST_REG_ACK;
        ST_REG_ACK:   state_d = ST_WDATA;
        ST_WDATA:     if (last_bit) state_d = ST_WDATA_ACK;
        ST_WDATA_ACK: state_d = ST_WDATA;
        ST_RDATA:     if (last_bit) state_d = ST_RD_MACK;
        ST_RD_MACK:   state_d = shift_q[0] ? ST_WAIT_STOP : ST_RDATA;
        default:      state_d = state_q;
      endcase
    end
  end

  // All SDA updates happen on scl_fall so the line only moves while SCL is low.
  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    reg_ptr_d   = reg_ptr_q;
    oe_d        = oe_q;
    busy_d      = busy_q;
    init1_d     = init1_q;
    hs_d        = hs_q;
    snap_pend_d = snap_pend_q;
    for (int i = 0; i < MAX_BYTES; i++) snap_d[i] = snap_q[i];

    if (stop_det) begin
      busy_d      = 1'b0;
      oe_d        = 1'b0;
      snap_pend_d = 1'b0;
      if (snap_pend_q) begin
        for (int i = 0; i < SNAP_N; i++) snap_d[i] = report[8*i +: 8];
      end
    end else if (start_det) begin
      busy_d    = 1'b1;
      oe_d      = 1'b0;
      bit_cnt_d = 4'd0;
    end else if (scl_rise) begin
      bit_cnt_d = bit_cnt_q + 4'd1;
      if (state_q inside {ST_ADDR, ST_REG, ST_WDATA, ST_RD_MACK})
        shift_d = {shift_q[6:0], sda_lvl};
    end else if (scl_fall) begin
      case (state_q)
        ST_ADDR: if (last_bit) begin
          bit_cnt_d = 4'd0;
          oe_d      = addr_match;
        end
        ST_ADDR_ACK: begin
          bit_cnt_d = 4'd0;
          tx_d      = rd_byte;
          oe_d      = shift_q[0] & ~rd_byte[7];
        end
        ST_REG: if (last_bit) begin
          bit_cnt_d   = 4'd0;
          reg_ptr_d   = shift_q;
          snap_pend_d = (shift_q == 8'h00);
          oe_d        = 1'b1;
        end
        ST_WDATA: if (last_bit) begin
          bit_cnt_d   = 4'd0;
          reg_ptr_d   = ptr_inc;
          snap_pend_d = 1'b0;
          oe_d        = 1'b1;
          if (reg_ptr_q == INIT_REG1 && shift_q == INIT_VAL1) init1_d = 1'b1;
          if (reg_ptr_q == INIT_REG2 && shift_q == INIT_VAL2 && init1_q) hs_d = 1'b1;
        end
        ST_REG_ACK, ST_WDATA_ACK: begin
          bit_cnt_d = 4'd0;
          oe_d      = 1'b0;
        end
        ST_RDATA: begin
          if (last_bit) begin
            bit_cnt_d = 4'd0;
            oe_d      = 1'b0;
          end else begin
            tx_d = {tx_q[6:0], 1'b1};
            oe_d = ~tx_q[6];
          end
        end
        ST_RD_MACK: begin
          bit_cnt_d = 4'd0;
          if (!shift_q[0]) begin
            reg_ptr_d = ptr_inc;
            tx_d      = nxt_byte;
            oe_d      = ~nxt_byte[7];
          end else begin
            oe_d = 1'b0;
          end
        end
        default: oe_d = 1'b0;
      endcase
    end
  end

  assign bus.sda_oe     = oe_q;
  assign handshake_done = hs_q;
  assign busy           = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_nunchuck_i2c_target.sv
// ============================================================================
// tb_nunchuck_i2c_target : directed I2C master bench for nunchuck_i2c_target
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_nunchuck_i2c_target;

  localparam int QTR = 80;

  logic       clock = 1'b0;
  logic       rst   = 1'b0;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic [7:0] stick_x = 8'h00, stick_y = 8'h00;
  logic [9:0] accel_x = 10'h000, accel_y = 10'h000, accel_z = 10'h000;
  logic       z = 1'b0, c = 1'b0;
  logic       hs, busy;
  int         n_vec = 0;
  int         n_err = 0;

  always #5 clock = ~clock;

  nunchuck_i2c_target_if bus ();
  assign bus.scl_in = m_scl;
  assign bus.sda_in = m_sda & ~bus.sda_oe;

  nunchuck_i2c_target #(.DEV_ADDR(7'h52), .MAX_BYTES(6), .SYNC_STAGES(2)) dut (
    .clock          (clock),
    .rst            (rst),
    .bus            (bus),
    .stick_x        (stick_x),
    .stick_y        (stick_y),
    .accel_x        (accel_x),
    .accel_y        (accel_y),
    .accel_z        (accel_z),
    .z              (z),
    .c              (c),
    .handshake_done (hs),
    .busy           (busy)
  );

  task automatic bus_start();
    m_sda = 1'b1; #QTR;
    m_scl = 1'b1; #QTR;
    m_sda = 1'b0; #QTR;
    m_scl = 1'b0; #QTR;
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; #QTR;
    m_scl = 1'b1; #QTR;
    m_sda = 1'b1; #QTR;
  endtask

  task automatic clock_bit(input logic b, output logic s);
    m_sda = b;    #QTR;
    m_scl = 1'b1; #QTR;
    s = bus.sda_in; #QTR;
    m_scl = 1'b0; #QTR;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
    clock_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s);
      d[i] = s;
    end
    clock_bit(nack, s);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #40;
    n_vec++; if (bus.sda_oe !== 1'b0) begin n_err++; $display("FAIL reset_sda_oe: got %b expected 0", bus.sda_oe); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_vec++; if (hs !== 1'b0) begin n_err++; $display("FAIL reset_handshake: got %b expected 0", hs); end
    rst = 1'b1;
    #40;
  endtask

  task automatic test_wrong_addr();
    logic ack;
    bus_start();
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL wrong_addr_busy: got %b expected 1", busy); end
    send_byte(8'hA6, ack);
    n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL wrong_addr_ack: got %b expected 0", ack); end
    n_vec++; if (bus.sda_oe !== 1'b0) begin n_err++; $display("FAIL wrong_addr_oe: got %b expected 0", bus.sda_oe); end
    bus_stop();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL wrong_addr_busy_stop: got %b expected 0", busy); end
    n_vec++; if (hs !== 1'b0) begin n_err++; $display("FAIL wrong_addr_hs: got %b expected 0", hs); end
  endtask

  task automatic test_read_prehandshake();
    logic ack;
    logic [7:0] d;
    bus_start();
    send_byte(8'hA5, ack);
    n_vec++; if (ack !== 1'b1) begin n_err++; $display("FAIL pre_hs_addr_ack: got %b expected 1", ack); end
    for (int i = 0; i < 6; i++) begin
      recv_byte(i == 5, d);
      n_vec++; if (d !== 8'hFF) begin n_err++; $display("FAIL pre_hs_byte%0d: got %h expected ff", i, d); end
    end
    bus_stop();
  endtask

  task automatic test_handshake();
    logic ack;
    logic [7:0] seq [4];
    seq = '{8'hF0, 8'h55, 8'hFB, 8'h00};
    for (int t = 0; t < 2; t++) begin
      bus_start();
      send_byte(8'hA4, ack);
      n_vec++; if (ack !== 1'b1) begin n_err++; $display("FAIL hs_addr_ack%0d: got %b expected 1", t, ack); end
      for (int k = 0; k < 2; k++) begin
        send_byte(seq[2*t+k], ack);
        n_vec++; if (ack !== 1'b1) begin n_err++; $display("FAIL hs_byte_ack%0d: got %b expected 1", 2*t+k, ack); end
      end
      n_vec++; if (hs !== (t == 1)) begin n_err++; $display("FAIL hs_done%0d: got %b expected %b", t, hs, (t == 1)); end
      bus_stop();
    end
  endtask

  task automatic test_snapshot_read();
    logic ack;
    logic [7:0] d;
    logic [7:0] exp_b [6];
    exp_b = '{8'h80, 8'h7F, 8'h80, 8'h7F, 8'hFF, 8'hE6};
    stick_x = 8'h80; stick_y = 8'h7F;
    accel_x = 10'h201; accel_y = 10'h1FE; accel_z = 10'h3FF;
    z = 1'b1; c = 1'b0;
    bus_start();
    send_byte(8'hA4, ack);
    send_byte(8'h00, ack);
    n_vec++; if (ack !== 1'b1) begin n_err++; $display("FAIL snap_reg_ack: got %b expected 1", ack); end
    bus_stop();
    bus_start();
    send_byte(8'hA5, ack);
    for (int i = 0; i < 6; i++) begin
      recv_byte(i == 5, d);
      n_vec++; if (d !== exp_b[i]) begin n_err++; $display("FAIL snap_byte%0d: got %h expected %h", i, d, exp_b[i]); end
    end
    n_vec++; if (bus.sda_oe !== 1'b0) begin n_err++; $display("FAIL snap_release: got %b expected 0", bus.sda_oe); end
    bus_stop();
  endtask

  task automatic test_repeated_start();
    logic ack;
    logic [7:0] d;
    logic [7:0] regs [2];
    logic [7:0] exp_b [4];
    regs  = '{8'h02, 8'h00};
    exp_b = '{8'h80, 8'h7F, 8'h80, 8'h7F};
    stick_x = 8'h11; stick_y = 8'h22;
    accel_x = 10'h000; accel_y = 10'h000; accel_z = 10'h000;
    z = 1'b0; c = 1'b0;
    for (int t = 0; t < 2; t++) begin
      bus_start();
      send_byte(8'hA4, ack);
      send_byte(regs[t], ack);
      bus_start();
      send_byte(8'hA5, ack);
      n_vec++; if (ack !== 1'b1) begin n_err++; $display("FAIL sr_addr_ack%0d: got %b expected 1", t, ack); end
      for (int i = 0; i < 2; i++) begin
        recv_byte(i == 1, d);
        n_vec++; if (d !== exp_b[2*t+i]) begin n_err++; $display("FAIL sr_byte%0d_%0d: got %h expected %h", t, i, d, exp_b[2*t+i]); end
      end
      bus_stop();
    end
  endtask

  task automatic test_reset_midread();
    logic ack;
    logic [7:0] d;
    bus_start();
    send_byte(8'hA4, ack);
    send_byte(8'h00, ack);
    bus_stop();
    bus_start();
    send_byte(8'hA5, ack);
    n_vec++; if (bus.sda_oe !== 1'b1) begin n_err++; $display("FAIL midread_driving: got %b expected 1", bus.sda_oe); end
    rst = 1'b0;
    #1;
    n_vec++; if (bus.sda_oe !== 1'b0) begin n_err++; $display("FAIL midread_release: got %b expected 0", bus.sda_oe); end
    n_vec++; if (hs !== 1'b0) begin n_err++; $display("FAIL midread_hs: got %b expected 0", hs); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL midread_busy: got %b expected 0", busy); end
    #39;
    rst = 1'b1;
    #40;
    bus_stop();
    bus_start();
    send_byte(8'hA5, ack);
    n_vec++; if (ack !== 1'b1) begin n_err++; $display("FAIL post_reset_ack: got %b expected 1", ack); end
    recv_byte(1'b1, d);
    n_vec++; if (d !== 8'hFF) begin n_err++; $display("FAIL post_reset_byte: got %h expected ff", d); end
    bus_stop();
  endtask

  initial begin
    test_reset();
    test_wrong_addr();
    test_read_prehandshake();
    test_handshake();
    test_snapshot_read();
    test_repeated_start();
    test_reset_midread();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
